// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and the initiator/slave-side FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: local cmd/rsp handshake to AW/W/B and AR/R channels,
// reporting the slave response code and a saturating command latency.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int LATW = 16
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdata,
    input  logic [DW/8-1:0] cmd_wstrb,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic [1:0]      rsp_resp,
    output logic [LATW-1:0] rsp_lat,
    output logic            AWVALID,
    output logic [AW-1:0]   AWADDR,
    input  logic            AWREADY,
    output logic            WVALID,
    output logic [DW-1:0]   WDATA,
    output logic [DW/8-1:0] WSTRB,
    input  logic            WREADY,
    input  logic            BVALID,
    input  logic [1:0]      BRESP,
    output logic            BREADY,
    output logic            ARVALID,
    output logic [AW-1:0]   ARADDR,
    input  logic            ARREADY,
    input  logic            RVALID,
    input  logic [DW-1:0]   RDATA,
    input  logic [1:0]      RRESP,
    output logic            RREADY
);

    localparam logic [LATW-1:0] LAT_ONE = {{(LATW-1){1'b0}}, 1'b1};
    localparam logic [LATW-1:0] LAT_MAX = {LATW{1'b1}};

    state_t          state_reg;
    logic            aw_done_reg;
    logic            w_done_reg;
    logic            aw_fire;
    logic            w_fire;
    logic [LATW-1:0] lat_next;

    assign aw_fire  = AWVALID & AWREADY;
    assign w_fire   = WVALID & WREADY;
    // The accept cycle itself counts as 1, so the counter runs from accept through the B/R edge.
    assign lat_next = (rsp_lat == LAT_MAX) ? rsp_lat : rsp_lat + LAT_ONE;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg   <= ST_IDLE;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_OKAY;
            rsp_lat     <= '0;
            AWVALID     <= 1'b0;
            AWADDR      <= '0;
            WVALID      <= 1'b0;
            WDATA       <= '0;
            WSTRB       <= '0;
            BREADY      <= 1'b0;
            ARVALID     <= 1'b0;
            ARADDR      <= '0;
            RREADY      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        rsp_lat   <= LAT_ONE;
                        if (cmd_write) begin
                            AWADDR      <= cmd_addr;
                            WDATA       <= cmd_wdata;
                            WSTRB       <= cmd_wstrb;
                            AWVALID     <= 1'b1;
                            WVALID      <= 1'b1;
                            aw_done_reg <= 1'b0;
                            w_done_reg  <= 1'b0;
                            state_reg   <= ST_WR_REQ;
                        end else begin
                            ARADDR    <= cmd_addr;
                            ARVALID   <= 1'b1;
                            state_reg <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    rsp_lat <= lat_next;
                    if (aw_fire) begin
                        AWVALID     <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end
                    if (w_fire) begin
                        WVALID     <= 1'b0;
                        w_done_reg <= 1'b1;
                    end
                    if ((aw_done_reg | aw_fire) & (w_done_reg | w_fire)) begin
                        BREADY    <= 1'b1;
                        state_reg <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    rsp_lat <= lat_next;
                    if (BVALID) begin
                        rsp_resp  <= BRESP;
                        rsp_rdata <= '0;
                        BREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_reg <= ST_RSP;
                    end
                end
                ST_RD_REQ: begin
                    rsp_lat <= lat_next;
                    if (ARREADY) begin
                        ARVALID   <= 1'b0;
                        RREADY    <= 1'b1;
                        state_reg <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    rsp_lat <= lat_next;
                    if (RVALID) begin
                        rsp_rdata <= RDATA;
                        rsp_resp  <= RRESP;
                        RREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_reg <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: delay-programmable AXI-Lite slave, memory reference model, scenario tasks.
module tb_axi_lite_master;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int LATW    = 4;
    localparam int LAT_MAX = 15;

    logic          ACLK;
    logic          ARESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [31:0]   cmd_addr, cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [3:0]    rsp_lat;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]   AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]    WSTRB;
    logic [1:0]    BRESP, RRESP;

    axi_lite_master #(.DW(DW), .AW(AW), .LATW(LATW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_lat(rsp_lat),
        .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
        .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WREADY(WREADY),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
        .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
        .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;

    int         cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
    logic [1:0] cfg_bresp, cfg_rresp;
    bit         cfg_b_early;
    int         aw_hs, w_hs, b_hs, ar_hs, r_hs, prot_err;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    // Slave model: drives every input on the falling edge, so the DUT samples settled values.
    initial begin
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                p_awv = 0; p_wv = 0; p_arv = 0;
                continue;
            end
            if (p_awv && !p_awr && (!AWVALID || AWADDR !== p_awaddr)) prot_err++;
            if (p_wv && !p_wr && (!WVALID || WDATA !== p_wdata || WSTRB !== p_wstrb)) prot_err++;
            if (p_arv && !p_arr && (!ARVALID || ARADDR !== p_araddr)) prot_err++;
            if (BREADY && (AWVALID || WVALID || ARVALID || RREADY)) prot_err++;
            if (RREADY && (ARVALID || AWVALID || WVALID)) prot_err++;
            if (AWVALID) begin
                AWREADY = (aw_cnt >= cfg_aw_dly); aw_cnt++;
                if (AWREADY) begin aw_hs++; cap_awaddr = AWADDR; end
            end else begin AWREADY = 0; aw_cnt = 0; end
            if (WVALID) begin
                WREADY = (w_cnt >= cfg_w_dly); w_cnt++;
                if (WREADY) begin w_hs++; cap_wdata = WDATA; cap_wstrb = WSTRB; end
            end else begin WREADY = 0; w_cnt = 0; end
            if (BREADY) begin
                BVALID = (b_cnt >= cfg_b_dly); b_cnt++; BRESP = cfg_bresp;
                if (BVALID) begin
                    logic [31:0] cur;
                    b_hs++;
                    cur = slv_mem.exists(cap_awaddr) ? slv_mem[cap_awaddr] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (cap_wstrb[b]) cur[8*b +: 8] = cap_wdata[8*b +: 8];
                    slv_mem[cap_awaddr] = cur;
                end
            end else begin
                b_cnt = 0; BRESP = cfg_bresp;
                BVALID = cfg_b_early && (AWVALID || WVALID);
            end
            if (ARVALID) begin
                ARREADY = (ar_cnt >= cfg_ar_dly); ar_cnt++;
                if (ARREADY) begin ar_hs++; cap_araddr = ARADDR; end
            end else begin ARREADY = 0; ar_cnt = 0; end
            if (RREADY) begin
                RVALID = (r_cnt >= cfg_r_dly); r_cnt++;
                if (RVALID) begin
                    r_hs++; RRESP = cfg_rresp;
                    RDATA = slv_mem.exists(cap_araddr) ? slv_mem[cap_araddr] : 32'h0;
                end
            end else begin RVALID = 0; r_cnt = 0; RDATA = $urandom; end
            p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
            p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wstrb = WSTRB;
            p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
        end
    end

    // One command end to end: expectations come from the slave delays and the reference memory.
    task automatic run_txn(input string name, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input int d1, input int d2, input int d3,
                           input logic [1:0] resp, input int hold, input bit early);
        int raw, exp_lat, cyc, bad;
        logic [31:0] exp_rdata, cur;
        logic [31:0] h_rdata;
        logic [1:0]  h_resp;
        logic [3:0]  h_lat;
        cfg_aw_dly = d1; cfg_ar_dly = d1; cfg_w_dly = d2; cfg_b_dly = d3; cfg_r_dly = d3;
        cfg_bresp = resp; cfg_rresp = resp; cfg_b_early = early;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; prot_err = 0;
        raw = wr ? 3 + ((d1 > d2) ? d1 : d2) + d3 : 3 + d1 + d3;
        exp_lat = (raw > LAT_MAX) ? LAT_MAX : raw;
        cur = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        if (wr) begin
            for (int b = 0; b < 4; b++) if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
            ref_mem[addr] = cur;
            exp_rdata = 32'h0;
        end else begin
            exp_rdata = cur;
        end
        @(negedge ACLK);
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin @(negedge ACLK); cyc++; end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s cmd_ready_wait: got %b want 1", name, cmd_ready);
        end
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        @(negedge ACLK);
        cmd_valid = 0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
        cyc = 1; bad = 0;
        while (!rsp_valid && cyc < 200) begin
            if (cmd_ready !== 1'b0) bad++;
            @(negedge ACLK); cyc++;
        end
        vectors++;
        if (cyc !== raw) begin
            miscompares++;
            $display("FAIL %s rsp_cycles: got %0d want %0d", name, cyc, raw);
        end
        vectors++;
        if ({rsp_valid, rsp_resp, rsp_rdata, rsp_lat} !== {1'b1, resp, exp_rdata, exp_lat[3:0]}) begin
            miscompares++;
            $display("FAIL %s payload: got v=%b resp=%b rdata=%h lat=%0d want v=1 resp=%b rdata=%h lat=%0d",
                     name, rsp_valid, rsp_resp, rsp_rdata, rsp_lat, resp, exp_rdata, exp_lat);
        end
        vectors++;
        if (wr ? {aw_hs, w_hs, b_hs, ar_hs, r_hs} !== {32'd1, 32'd1, 32'd1, 32'd0, 32'd0}
               : {aw_hs, w_hs, b_hs, ar_hs, r_hs} !== {32'd0, 32'd0, 32'd0, 32'd1, 32'd1}) begin
            miscompares++;
            $display("FAIL %s handshakes: got aw=%0d w=%0d b=%0d ar=%0d r=%0d want %s",
                     name, aw_hs, w_hs, b_hs, ar_hs, r_hs, wr ? "1/1/1/0/0" : "0/0/0/1/1");
        end
        vectors++;
        if (wr ? {cap_awaddr, cap_wdata, cap_wstrb} !== {addr, data, strb} : cap_araddr !== addr) begin
            miscompares++;
            $display("FAIL %s channel_payload: got aw=%h w=%h s=%h ar=%h want addr=%h data=%h strb=%h",
                     name, cap_awaddr, cap_wdata, cap_wstrb, cap_araddr, addr, data, strb);
        end
        h_rdata = rsp_rdata; h_resp = rsp_resp; h_lat = rsp_lat;
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            if (!rsp_valid || cmd_ready || rsp_rdata !== h_rdata || rsp_resp !== h_resp || rsp_lat !== h_lat)
                bad++;
        end
        rsp_ready = 1;
        @(negedge ACLK);
        rsp_ready = 0;
        vectors++;
        if ({rsp_valid, cmd_ready} !== 2'b01 || bad != 0 || prot_err != 0) begin
            miscompares++;
            $display("FAIL %s hold_release: got rsp_valid=%b cmd_ready=%b hold_errs=%0d prot_errs=%0d want 0 1 0 0",
                     name, rsp_valid, cmd_ready, bad, prot_err);
        end
        $display("txn %s wr=%0d addr=%h data=%h strb=%h resp=%b rdata=%h lat=%0d cycles=%0d",
                 name, wr, addr, data, strb, h_resp, h_rdata, h_lat, cyc);
    endtask

    task automatic test_reset();
        ARESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
        cfg_bresp = 0; cfg_rresp = 0; cfg_b_early = 0; prot_err = 0;
        #22;
        vectors++;
        if ({cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_handshakes: got %b want 1000000",
                     {cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY});
        end
        vectors++;
        if ({rsp_rdata, rsp_resp, rsp_lat, AWADDR, WDATA, WSTRB, ARADDR} !== '0) begin
            miscompares++;
            $display("FAIL reset_payload: got rdata=%h resp=%b lat=%0d awaddr=%h wdata=%h wstrb=%h araddr=%h want all 0",
                     rsp_rdata, rsp_resp, rsp_lat, AWADDR, WDATA, WSTRB, ARADDR);
        end
        @(negedge ACLK); #2 ARESETn = 1;
        $display("txn reset done");
    endtask

    task automatic test_write_basic();
        run_txn("write_zero_wait", 1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic test_write_skew();
        run_txn("write_aw1_w4", 1, 32'h0000_0014, 32'h1234_5678, 4'h5, 1, 4, 1, 2'b00, 1, 0);
    endtask

    task automatic test_read_basic();
        slv_mem[32'h0000_0020] = 32'hDEAD_BEEF;
        ref_mem[32'h0000_0020] = 32'hDEAD_BEEF;
        run_txn("read_deadbeef", 0, 32'h0000_0020, 32'h0, 4'h0, 1, 0, 1, 2'b00, 0, 0);
    endtask

    task automatic test_read_error_hold();
        run_txn("read_slverr_hold5", 0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 2, 2'b10, 5, 0);
    endtask

    task automatic test_early_bvalid();
        run_txn("write_early_bvalid", 1, 32'h0000_0018, 32'hCAFE_F00D, 4'hC, 2, 3, 0, 2'b11, 0, 1);
    endtask

    task automatic test_lat_saturate();
        run_txn("write_lat_sat", 1, 32'h0000_001C, 32'h0BAD_C0DE, 4'hF, 2, 20, 0, 2'b01, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_write", 1, 32'h0000_0004, 32'h1111_2222, 4'hF, 0, 0, 0, 2'b00, 0, 0);
        run_txn("b2b_read", 0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            bit wr;
            logic [31:0] a;
            wr = $urandom_range(0, 1);
            a  = 32'($urandom_range(0, 7)) << 2;
            run_txn($sformatf("rand%0d", n), wr, a, $urandom, 4'($urandom),
                    $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 6),
                    2'($urandom), $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        cfg_aw_dly = 0; cfg_w_dly = 50; cfg_b_dly = 0; cfg_b_early = 0;
        @(negedge ACLK);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_0008; cmd_wdata = 32'hFFFF_0000; cmd_wstrb = 4'hF;
        @(negedge ACLK);
        cmd_valid = 0;
        repeat (3) @(negedge ACLK);
        vectors++;
        if ({WVALID, AWVALID} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_mid_pre: got WVALID=%b AWVALID=%b want 1 0", WVALID, AWVALID);
        end
        #2 ARESETn = 0;
        #1;
        vectors++;
        if ({cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %b want 1000000",
                     {cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY});
        end
        repeat (2) @(negedge ACLK);
        #2 ARESETn = 1;
        repeat (4) @(negedge ACLK);
        vectors++;
        if ({cmd_ready, rsp_valid, WVALID, BREADY} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_mid_after: got cmd_ready=%b rsp_valid=%b WVALID=%b BREADY=%b want 1 0 0 0",
                     cmd_ready, rsp_valid, WVALID, BREADY);
        end
        $display("txn reset_mid abandoned write to 00000008");
        run_txn("read_after_reset", 0, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_skew();
        test_read_basic();
        test_read_error_hold();
        test_early_bvalid();
        test_lat_saturate();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
